// File: rtl/csp_pkg.sv
// Shared types for the clocked one-place CSP channel.
package csp_pkg;

    // Handshake flavour selected per channel instance.
    typedef enum logic {
        P2PHASE_BD,
        P4PHASE_BD
    } hs_protocol_e;

    // Sender-side controller states (4-phase only).
    typedef enum logic {
        S_IDLE,
        S_ACK
    } snd_state_e;

    // Receiver-side controller states (4-phase only).
    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_WAIT
    } rcv_state_e;

    localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/csp_channel_if.sv
// Bundled-data handshake bundle between a sender, the channel and a receiver.
interface csp_channel_if #(
    parameter int WIDTH = 8
);
    logic             s_req;
    logic [WIDTH-1:0] s_data;
    logic             s_ack;
    logic             r_req;
    logic [WIDTH-1:0] r_data;
    logic             r_ack;

    // Channel side: accepts tokens from the sender, offers them to the receiver.
    modport slave (
        input  s_req, s_data, r_ack,
        output s_ack, r_req, r_data
    );

    // Environment side: drives the sender and receiver halves.
    modport master (
        output s_req, s_data, r_ack,
        input  s_ack, r_req, r_data
    );
endinterface

// File: rtl/csp_channel.sv
// One-place CSP channel: a single token buffer between a sender and a
// receiver, speaking either 4-phase or 2-phase bundled-data handshakes.
// Every output comes straight from a register.
module csp_channel
    import csp_pkg::*;
#(
    parameter int           WIDTH    = 8,
    parameter hs_protocol_e PROTOCOL = P4PHASE_BD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    csp_channel_if.slave          ch,
    output logic                  full,
    output logic [XFER_CNT_W-1:0] xfer_count
);

    logic [WIDTH-1:0] buf_q;
    logic             s_ack_q;
    logic             r_req_q;
    logic             capture;

    assign ch.r_data = buf_q;
    assign ch.s_ack  = s_ack_q;
    assign ch.r_req  = r_req_q;

    if (PROTOCOL == P4PHASE_BD) begin : g_p4
        snd_state_e s_state;
        rcv_state_e r_state;

        // A raised request is only taken once per handshake, and only into an empty buffer.
        assign capture = ch.s_req && (s_state == S_IDLE) && !full;

        // Sender controller: latch the token, hold ack until the request returns to zero.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s_state <= S_IDLE;
                s_ack_q <= 1'b0;
                buf_q   <= '0;
            end else begin
                case (s_state)
                    S_IDLE: begin
                        if (capture) begin
                            buf_q   <= ch.s_data;
                            s_ack_q <= 1'b1;
                            s_state <= S_ACK;
                        end
                    end
                    S_ACK: begin
                        if (!ch.s_req) begin
                            s_ack_q <= 1'b0;
                            s_state <= S_IDLE;
                        end
                    end
                    default: s_state <= S_IDLE;
                endcase
            end
        end

        // Receiver controller: offer the buffered token, free the buffer on ack, wait for ack to drop.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state    <= R_IDLE;
                r_req_q    <= 1'b0;
                full       <= 1'b0;
                xfer_count <= '0;
            end else begin
                // Capture needs an empty buffer and release needs a full one,
                // so the two never land on the same edge.
                if (capture) full <= 1'b1;
                case (r_state)
                    R_IDLE: begin
                        if (full && !ch.r_ack) begin
                            r_req_q <= 1'b1;
                            r_state <= R_REQ;
                        end
                    end
                    R_REQ: begin
                        if (ch.r_ack) begin
                            r_req_q    <= 1'b0;
                            full       <= 1'b0;
                            xfer_count <= xfer_count + 1'b1;
                            r_state    <= R_WAIT;
                        end
                    end
                    R_WAIT: begin
                        if (!ch.r_ack) r_state <= R_IDLE;
                    end
                    default: r_state <= R_IDLE;
                endcase
            end
        end
    end else begin : g_p2
        // Set while r_req has been toggled for the current token and its ack is outstanding.
        logic offered;

        // Any request/ack disagreement is a new token.
        assign capture = (ch.s_req != s_ack_q) && !full;

        // Sender side: latch the token and answer with an ack transition.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s_ack_q <= 1'b0;
                buf_q   <= '0;
            end else if (capture) begin
                buf_q   <= ch.s_data;
                s_ack_q <= ~s_ack_q;
            end
        end

        // Receiver side: toggle r_req once per token, release when r_ack catches up.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_req_q    <= 1'b0;
                offered    <= 1'b0;
                full       <= 1'b0;
                xfer_count <= '0;
            end else begin
                if (capture) full <= 1'b1;
                if (full && !offered) begin
                    r_req_q <= ~r_req_q;
                    offered <= 1'b1;
                end else if (offered && (ch.r_ack == r_req_q)) begin
                    full       <= 1'b0;
                    offered    <= 1'b0;
                    xfer_count <= xfer_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_csp_channel.sv
// Directed bench for csp_channel: two 4-phase instances (13 and 21 bits) and
// one 8-bit 2-phase instance driven from a single linear stimulus sequence.
module tb_csp_channel;
    import csp_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    csp_channel_if #(.WIDTH(13)) ia ();
    csp_channel_if #(.WIDTH(21)) ib ();
    csp_channel_if #(.WIDTH(8))  ic ();

    logic        fa, fb, fc;
    logic [15:0] ca, cb, cc;

    csp_channel #(.WIDTH(13), .PROTOCOL(P4PHASE_BD)) u_a (
        .clk(clk), .rst_n(rst_n), .ch(ia), .full(fa), .xfer_count(ca));
    csp_channel #(.WIDTH(21), .PROTOCOL(P4PHASE_BD)) u_b (
        .clk(clk), .rst_n(rst_n), .ch(ib), .full(fb), .xfer_count(cb));
    csp_channel #(.WIDTH(8), .PROTOCOL(P2PHASE_BD)) u_c (
        .clk(clk), .rst_n(rst_n), .ch(ic), .full(fc), .xfer_count(cc));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    logic tog_s, tog_r;
    int   sent, del, bad, cyc;

    initial begin
        // Reset with requests and acks held high
        rst_n = 1'b0;
        ia.s_req = 1'b1; ia.r_ack = 1'b1; ia.s_data = '0;
        ib.s_req = 1'b1; ib.r_ack = 1'b1; ib.s_data = '0;
        ic.s_req = 1'b1; ic.r_ack = 1'b1; ic.s_data = '0;
        repeat (3) nx();
        check("rst_a_sack", ia.s_ack, 0);
        check("rst_a_rreq", ia.r_req, 0);
        check("rst_a_full", fa, 0);
        check("rst_a_cnt", ca, 0);
        check("rst_c_sack", ic.s_ack, 0);
        check("rst_c_rreq", ic.r_req, 0);
        check("rst_b_full", fb, 0);
        ia.s_req = 1'b0; ia.r_ack = 1'b0;
        ib.s_req = 1'b0; ib.r_ack = 1'b0;
        ic.s_req = 1'b0; ic.r_ack = 1'b0;
        nx();
        rst_n = 1'b1;
        nx();

        // 4-phase single token
        ia.s_data = 13'd10; ia.s_req = 1'b1;
        nx();
        check("p4_sack_capture", ia.s_ack, 1);
        check("p4_full_capture", fa, 1);
        check("p4_rreq_not_yet", ia.r_req, 0);
        nx();
        check("p4_rreq_offer", ia.r_req, 1);
        check("p4_rdata", ia.r_data, 13'd10);
        ia.s_req = 1'b0; ia.r_ack = 1'b1;
        nx();
        check("p4_sack_drop", ia.s_ack, 0);
        check("p4_rreq_drop", ia.r_req, 0);
        check("p4_full_clr", fa, 0);
        check("p4_cnt1", ca, 1);
        ia.r_ack = 1'b0;
        nx();

        // Stray ack with nothing offered
        ia.r_ack = 1'b1;
        repeat (2) nx();
        check("p4_stray_rreq", ia.r_req, 0);
        check("p4_stray_cnt", ca, 1);
        ia.r_ack = 1'b0;
        nx();

        // Backpressure: second token waits while the first is unacknowledged
        ib.s_data = 21'h0A0005; ib.s_req = 1'b1;
        nx();
        check("bp_sack1", ib.s_ack, 1);
        ib.s_req = 1'b0;
        nx();
        check("bp_rreq1", ib.r_req, 1);
        ib.s_data = 21'h1F1234; ib.s_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            nx();
            check("bp_sack_hold", ib.s_ack, 0);
            check("bp_full_hold", fb, 1);
        end
        check("bp_rdata1", ib.r_data, 21'h0A0005);
        ib.r_ack = 1'b1;
        nx();
        check("bp_cnt1", cb, 1);
        check("bp_full_clr1", fb, 0);
        ib.r_ack = 1'b0;
        nx();
        check("bp_sack2", ib.s_ack, 1);
        check("bp_full2", fb, 1);
        ib.s_req = 1'b0;
        nx();
        check("bp_rreq2", ib.r_req, 1);
        check("bp_rdata2", ib.r_data, 21'h1F1234);
        ib.r_ack = 1'b1;
        nx();
        check("bp_cnt2", cb, 2);
        check("bp_full_clr2", fb, 0);
        ib.r_ack = 1'b0;
        nx();

        // 2-phase: five tokens by transition
        tog_s = 1'b0; tog_r = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ic.s_data = i[7:0];
            tog_s = ~tog_s;
            ic.s_req = tog_s;
            nx();
            check("p2_sack", ic.s_ack, tog_s);
            nx();
            tog_r = ~tog_r;
            check("p2_rreq", ic.r_req, tog_r);
            check("p2_rdata", ic.r_data, i);
            ic.r_ack = tog_r;
            nx();
            check("p2_cnt", cc, i);
            check("p2_full", fc, 0);
        end

        // Reset in the middle of a 4-phase delivery
        ia.s_data = 13'd3; ia.s_req = 1'b1;
        nx();
        ia.s_req = 1'b0;
        nx();
        check("mid_pre_full", fa, 1);
        check("mid_pre_rreq", ia.r_req, 1);
        rst_n = 1'b0;
        ic.s_req = 1'b0; ic.r_ack = 1'b0;
        repeat (2) nx();
        check("mid_sack", ia.s_ack, 0);
        check("mid_rreq", ia.r_req, 0);
        check("mid_full", fa, 0);
        check("mid_cnt", ca, 0);
        check("mid_rdata", ia.r_data, 0);
        rst_n = 1'b1;
        nx();
        ia.s_data = 13'd7; ia.s_req = 1'b1;
        nx();
        check("mid_tok_sack", ia.s_ack, 1);
        nx();
        check("mid_tok_rreq", ia.r_req, 1);
        check("mid_tok_rdata", ia.r_data, 13'd7);
        ia.s_req = 1'b0; ia.r_ack = 1'b1;
        nx();
        check("mid_tok_cnt", ca, 1);
        check("mid_tok_full", fa, 0);
        ia.r_ack = 1'b0;
        nx();

        // Counter wrap: 65536 back-to-back 2-phase transfers from a fresh reset
        sent = 0; del = 0; bad = 0; cyc = 0;
        while (del != 65536 && cyc < 220000) begin
            nx();
            cyc++;
            if (cc !== del[15:0]) bad++;
            if (ic.r_req != ic.r_ack) begin
                if (ic.r_data !== del[7:0]) bad++;
                ic.r_ack = ic.r_req;
                del++;
            end
            if (sent < 65536 && ic.s_ack == ic.s_req) begin
                ic.s_data = sent[7:0];
                ic.s_req = ~ic.s_req;
                sent++;
            end
        end
        nx();
        check("wrap_track", bad, 0);
        check("wrap_delivered", del, 65536);
        check("wrap_cnt", cc, 0);
        check("wrap_full", fc, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csp_channel.md
# csp_channel

Synthesizable, clocked, one-place CSP channel. A sender and a receiver exchange WIDTH-bit tokens over bundled-data request/acknowledge handshakes, in either 4-phase (return-to-zero) or 2-phase (transition) signalling. It is the point-to-point link between PE sub-units (split, register files, control, multiplier, adder, accumulator) and between PEs and the network.

## Interface
Parameters:
- WIDTH, 8: token width in bits; legal 1..64.
- PROTOCOL, P4PHASE_BD: handshake protocol, type hs_protocol_e, values P4PHASE_BD or P2PHASE_BD.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- s_req  in  1  sender request.
- s_data  in  WIDTH  sender token; stable while the request is pending.
- s_ack  out  1  sender acknowledge.
- r_req  out  1  receiver request (token valid).
- r_data  out  WIDTH  token offered to the receiver.
- r_ack  in  1  receiver acknowledge.
- full  out  1  buffer holds an undelivered token.
- xfer_count  out  16  completed deliveries; wraps at 65535 -> 0.

## Operation
- All inputs are synchronous to clk. The block contains no synchronizers.
- One internal token buffer, `buf`. r_data is driven directly from `buf`.
- Sender pending condition:
  - 4-phase: s_req == 1 and sender FSM in S_IDLE.
  - 2-phase: s_req != s_ack.
- Capture: when a token is pending and full == 0 before the edge, at that edge `buf` <= s_data and full <= 1.
  - 4-phase: s_ack <= 1 and the sender FSM enters S_ACK.
  - 2-phase: s_ack toggles.
- Sender FSM (4-phase only):
  - S_IDLE: go to S_ACK on capture.
  - S_ACK: when s_req == 0, set s_ack <= 0 and return to S_IDLE.
- Receiver FSM, 4-phase:
  - R_IDLE: if full == 1 and r_ack == 0, set r_req <= 1 and go to R_REQ.
  - R_REQ: when r_ack == 1, set r_req <= 0, full <= 0, increment xfer_count, and go to R_WAIT.
  - R_WAIT: when r_ack == 0, go to R_IDLE.
- Receiver, 2-phase:
  - When full == 1 and r_req == r_ack (no offer outstanding), toggle r_req.
  - When r_ack toggles to equal r_req, set full <= 0 and increment xfer_count.
- If full == 1, a pending sender token waits. It is captured at the first edge where full was 0 beforehand. A capture and a release never occur at the same edge.
- 4-phase protocol violations:
  - s_req dropped before capture: no token is captured.
  - s_data changing after capture: ignored.
  - r_ack raised in R_IDLE: ignored.
- Reset: s_ack=0, r_req=0, r_data=0, full=0, xfer_count=0, FSMs in S_IDLE/R_IDLE, `buf` cleared. This applies regardless of state, including mid-handshake. Tokens in flight are discarded.

## Timing
- Capture-to-offer latency: r_req asserts (or toggles) one cycle after the capture edge.
- s_ack responds on the capture edge. The sender sees it one cycle after s_req was sampled with the buffer empty.
- 4-phase minimum token period: capture at edge k, r_req at k+1, earliest r_ack sample at k+2 (full clears), earliest next capture at k+3.
- Back-to-back 2-phase tokens follow the same edge spacing.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package csp_pkg:
  - typedef enum hs_protocol_e {P2PHASE_BD, P4PHASE_BD}.
  - Sender FSM state typedef (S_IDLE, S_ACK).
  - Receiver FSM state typedef (R_IDLE, R_REQ, R_WAIT).
- No sub-module: sender and receiver controllers are two always_ff processes sharing `buf` and `full`.
- Protocol selection uses generate-if on PROTOCOL.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with s_req=1 and r_ack=1. Required: s_ack=0, r_req=0, full=0, xfer_count=0.
- 4-phase single token, WIDTH=13:
  - Send s_data=13'd10. Required: s_ack=1 at capture edge, r_req=1 next cycle with r_data=10.
  - Receiver acks. Required: r_req=0, full=0, xfer_count=1.
- Backpressure: send 21'h0A0005 and 21'h1F1234 with r_ack withheld for 10 cycles. Required: second s_ack stays 0 while full=1; data delivered in order 0A0005 then 1F1234; xfer_count=2.
- 2-phase: five tokens 1..5 sent by toggling s_req. Required: s_ack toggles once per token, r_req toggles once per token, r_data sequence 1,2,3,4,5.
- Reset mid-handshake: assert rst_n=0 while in R_REQ with full=1. Required: all outputs return to reset values; a subsequent token 13'd7 is delivered correctly.
- Counter wrap: complete 65536 transfers. Required: xfer_count reads 0.
